// File: rtl/fifo_core.sv
// fifo_core: single-clock circular-buffer FIFO with registered occupancy flags and a protocol-error pulse
module fifo_core #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 16,
  parameter int ALMOST_FULL  = 12,
  parameter int ALMOST_EMPTY = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             almost_empty,
  output logic             almost_full,
  output logic             full,
  output logic             error
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] AF  = (AW+1)'(ALMOST_FULL);
  localparam logic [AW:0] AE  = (AW+1)'(ALMOST_EMPTY);
  localparam logic [AW:0] FC  = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_nx;
  logic             do_push, do_pop;
  // a pop frees a slot at the same edge, so a push on full is legal when paired with a pop
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  always_comb
    count_nx = (do_push && !do_pop) ? count + ONE :
               (do_pop && !do_push) ? count - ONE : count;
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= data_in;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      data_out     <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      full         <= 1'b0;
      error        <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        data_out <= mem[rd_ptr];
      end
      count        <= count_nx;
      empty        <= count_nx == '0;
      almost_empty <= count_nx <= AE;
      almost_full  <= count_nx >= AF;
      full         <= count_nx == FC;
      error        <= (push && full && !pop) || (pop && empty);
    end
endmodule
